// File: rtl/flash_arbiter.sv
// flash_arbiter: grants one of three requesters ownership of the SPI flash
// interface, muxes the owner's command fields through, and routes the flash
// done pulses back to the owner. Non-preemptive fixed priority, one-cycle
// holdoff between grants, and a watchdog that force-releases a stuck owner.
module flash_arbiter #(
   parameter logic [27:0] TIMEOUT = 28'd200_000_000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [2:0]   req_in_progress,
   input  logic [2:0]   req_store_flash_command,
   input  logic [20:0]  req_wbuf_address,
   input  logic [95:0]  req_flash_command,
   input  logic [35:0]  req_flash_wr_nBits,
   input  logic [2:0]   req_send_write_command,
   input  logic [2:0]   req_read_bitstream,
   output logic         store_flash_command,
   output logic [6:0]   wbuf_address,
   output logic [31:0]  flash_command,
   output logic [11:0]  flash_wr_nBits,
   output logic         send_write_command,
   output logic         read_bitstream,
   input  logic         end_write_command,
   input  logic         end_bitstream,
   output logic [2:0]   grant,
   output logic [2:0]   req_end_write_command,
   output logic [2:0]   req_end_bitstream,
   output logic         flash_busy,
   output logic [1:0]   owner,
   output logic         timeout_err,
   output logic [1:0]   state,
   input  logic         clr_timeout_err
);

   localparam int unsigned N_REQ   = 3;
   localparam int unsigned WBUF_W  = 7;
   localparam int unsigned CMD_W   = 32;
   localparam int unsigned NBITS_W = 12;
   localparam int unsigned WDOG_W  = 28;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWNED   = 2'd1,
      HOLDOFF = 2'd2
   } state_e;

   localparam logic [1:0] OWNER_NONE = 2'd3;

   state_e              state_q, state_d;
   logic [1:0]          owner_q, owner_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic [N_REQ-1:0]    lock_q, lock_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;

   logic [N_REQ-1:0]    eligible;
   logic                sel_valid;
   logic [1:0]          sel_idx;
   logic                owner_req;
   logic                timeout_set;

   // Fixed-priority pick among requesters not locked out; index 0 wins.
   always_comb begin
      eligible  = req_in_progress & ~lock_q;
      sel_valid = 1'b0;
      sel_idx   = 2'd0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_valid = 1'b1;
            sel_idx   = 2'(i);
         end
      end
   end

   // Grant lifecycle: next state, owner, watchdog, lockout and sticky error.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      grant_d     = grant_q;
      wdog_d      = wdog_q;
      lock_d      = lock_q & req_in_progress;
      timeout_set = 1'b0;
      owner_req   = |(req_in_progress & grant_q);

      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               state_d = OWNED;
               owner_d = sel_idx;
               grant_d = 3'b001 << sel_idx;
               wdog_d  = '0;
            end
         end
         OWNED: begin
            if (!owner_req) begin
               state_d = HOLDOFF;
               owner_d = OWNER_NONE;
               grant_d = '0;
               wdog_d  = '0;
            end else if (wdog_q == TIMEOUT - 28'd1) begin
               // Force release; the owner must drop its request before re-grant.
               state_d     = HOLDOFF;
               owner_d     = OWNER_NONE;
               grant_d     = '0;
               wdog_d      = '0;
               lock_d      = lock_d | grant_q;
               timeout_set = 1'b1;
            end else begin
               wdog_d = wdog_q + 28'd1;
            end
         end
         HOLDOFF: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            owner_d = OWNER_NONE;
            grant_d = '0;
            wdog_d  = '0;
         end
      endcase

      err_d  = timeout_set | (err_q & ~clr_timeout_err);
      busy_d = (state_d != IDLE);
   end

   // State and bookkeeping registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWNER_NONE;
         grant_q <= '0;
         wdog_q  <= '0;
         lock_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         wdog_q  <= wdog_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // Flash-side mux: only the owner's fields pass, and only while OWNED.
   always_comb begin
      store_flash_command = 1'b0;
      wbuf_address        = '0;
      flash_command       = '0;
      flash_wr_nBits      = '0;
      send_write_command  = 1'b0;
      read_bitstream      = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (state_q == OWNED && grant_q[i]) begin
            store_flash_command = req_store_flash_command[i];
            wbuf_address        = req_wbuf_address[WBUF_W*i +: WBUF_W];
            flash_command       = req_flash_command[CMD_W*i +: CMD_W];
            flash_wr_nBits      = req_flash_wr_nBits[NBITS_W*i +: NBITS_W];
            send_write_command  = req_send_write_command[i];
            read_bitstream      = req_read_bitstream[i];
         end
      end
   end

   // Done pulses go back to the owner only.
   always_comb begin
      req_end_write_command = '0;
      req_end_bitstream     = '0;
      if (state_q == OWNED) begin
         req_end_write_command = grant_q & {N_REQ{end_write_command}};
         req_end_bitstream     = grant_q & {N_REQ{end_bitstream}};
      end
   end

   assign grant       = grant_q;
   assign owner       = owner_q;
   assign timeout_err = err_q;
   assign flash_busy  = busy_q;
   assign state       = state_q;

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 28'd200_000_000, which sets the maximum number of clk cycles one grant may be held.
REQ-002 SHALL have port clk, input, 1 bit: the single clock domain.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-004 SHALL have port req_in_progress, input, 3 bits: per-requester ownership request (0 = channel programmer, 1 = IPbus flash access, 2 = FPGA reprogram loader).
REQ-005 SHALL have port req_store_flash_command, input, 3 bits: per-requester WBUF store strobe.
REQ-006 SHALL have port req_wbuf_address, input, 21 bits: three packed 7-bit fields, requester i at [7i+6:7i].
REQ-007 SHALL have port req_flash_command, input, 96 bits: three packed 32-bit fields.
REQ-008 SHALL have port req_flash_wr_nBits, input, 36 bits: three packed 12-bit fields.
REQ-009 SHALL have ports req_send_write_command and req_read_bitstream, input, 3 bits each: per-requester start strobes.
REQ-010 SHALL have outputs store_flash_command (1), wbuf_address (7), flash_command (32), flash_wr_nBits (12), send_write_command (1) and read_bitstream (1), all driven to spi_flash_intf.
REQ-011 SHALL have inputs end_write_command and end_bitstream, 1 bit each: done pulses from spi_flash_intf.
REQ-012 SHALL have outputs grant (3), req_end_write_command (3) and req_end_bitstream (3): per-requester grant and routed done signals.
REQ-013 SHALL have outputs flash_busy (1), owner (2; 3 = none), timeout_err (1, sticky) and state (2).
REQ-014 SHALL have input clr_timeout_err, 1 bit: synchronous clear for timeout_err.

Function
REQ-015 SHALL implement the states IDLE=0, OWNED=1 and HOLDOFF=2.
REQ-016 SHALL, in IDLE, select the lowest-index requester with req_in_progress high, using fixed priority 0 > 1 > 2.
REQ-017 SHALL, when a requester is selected in IDLE at cycle N, register owner and the one-hot grant, move to OWNED, and present grant high at cycle N+1.
REQ-018 SHALL, in OWNED, drive every flash-side output as a combinational copy of the owner's corresponding field.
REQ-019 SHALL drive all flash-side outputs to 0 in IDLE and HOLDOFF, and SHALL ignore strobes from ungranted requesters at all times.
REQ-020 SHALL route end_write_command and end_bitstream combinationally to the owner's bit only; all other bits are 0, and all bits are 0 outside OWNED.
REQ-021 SHALL, when the owner's req_in_progress is low in OWNED, clear grant and set owner to 3 on the next edge, then enter HOLDOFF.
REQ-022 SHALL remain in HOLDOFF for exactly 1 cycle and then enter IDLE, so the minimum gap between grants is 2 cycles with no flash strobes.
REQ-023 SHALL NOT pre-empt an active grant: a higher-priority request arriving during OWNED waits until the flash returns to IDLE.
REQ-024 SHALL use a 28-bit watchdog counter that clears on grant and increments on each OWNED cycle.
REQ-025 SHALL, when the watchdog reaches TIMEOUT-1 while still OWNED, force release as in REQ-021 and set timeout_err.
REQ-026 SHALL NOT re-grant a requester that was force-released until it has deasserted req_in_progress for at least 1 cycle (per-requester lockout bit, cleared by that deassertion).
REQ-027 SHALL hold timeout_err at 1 until reset or clr_timeout_err; if a new timeout and clr_timeout_err coincide, the set wins.
REQ-028 SHALL drive flash_busy = (state != IDLE).
REQ-029 SHALL give simultaneous requests in IDLE to the lowest index; the others keep waiting with no lost requests.
REQ-030 SHALL, if the owner drops req_in_progress in the same cycle an end pulse arrives, still route that pulse to the owner.

Reset
REQ-031 SHALL, on reset (including mid-grant), return on the next edge to state=IDLE, grant=0, owner=3, watchdog=0, all lockout bits=0 and timeout_err=0, with all flash-side and routed outputs 0.
REQ-032 SHALL give reset priority over every other input.

Verification
REQ-033 SHALL be verified with: req_in_progress=3'b001 in IDLE -> grant=3'b001 one cycle later; flash_command equals req_flash_command[31:0]; end_write_command pulse -> req_end_write_command=3'b001.
REQ-034 SHALL be verified with: req_in_progress=3'b110 in the same cycle -> grant=3'b010; after bit1 drops, HOLDOFF for 1 cycle, then grant=3'b100.
REQ-035 SHALL be verified with: requester 1 owned, requester 0 asserts -> grant stays 3'b010 until release, then 3'b001 after HOLDOFF.
REQ-036 SHALL be verified with: TIMEOUT=16 and requester 2 held high -> forced release after 16 OWNED cycles, timeout_err=1, and no re-grant until bit2 drops for 1 cycle.
REQ-037 SHALL be verified with: reset during OWNED while read_bitstream is high -> next cycle read_bitstream=0, grant=0, owner=3, state=IDLE.
REQ-038 SHALL be verified with: requester 1 asserting req_send_write_command while requester 0 owns -> send_write_command follows requester 0 only.
